// File: rtl/host_entry_ctrl.sv
// Host secret-word entry sequencer: edge-detects keystrokes, filters and upper-cases
// letters, handles backspace/enter, and locks the word for the length of a game.
module host_entry_ctrl #(
   parameter int         WORD_LEN = 5,
   parameter int         IDX_W    = 3,
   parameter logic [7:0] BKSP     = 8'h08,
   parameter logic [7:0] ENTER    = 8'h0D,
   parameter logic [7:0] BLANK    = 8'h5F
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             key_ready,
   input  logic [7:0]       setLetter,
   input  logic             toggle_state,
   input  logic             gameEnd_host,
   output logic             wr_en,
   output logic [IDX_W-1:0] wr_idx,
   output logic [7:0]       wr_data,
   output logic             clr_word,
   output logic             word_commit,
   output logic             word_locked,
   output logic [IDX_W:0]   letter_cnt,
   output logic             key_err,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, LOCKED = 2'd2} state_t;

   typedef struct packed {
      logic             wr_en;
      logic [IDX_W-1:0] wr_idx;
      logic [7:0]       wr_data;
      logic             clr_word;
      logic             word_commit;
      logic             key_err;
   } resp_t;

   localparam logic [IDX_W:0] FULL = WORD_LEN[IDX_W:0];
   localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

   state_t         state_q, state_n;
   resp_t          rsp_q, rsp_n;
   logic [IDX_W:0] cnt_q, cnt_n;
   logic [IDX_W:0] cnt_dec;
   logic           key_ready_q;
   logic           key_ev;
   logic           is_up, is_lo;
   logic [7:0]     up_char;

   // Edge register runs in every state so a key held across a state change
   // cannot produce a second event.
   assign key_ev  = key_ready & ~key_ready_q;
   assign is_up   = (setLetter >= 8'h41) && (setLetter <= 8'h5A);
   assign is_lo   = (setLetter >= 8'h61) && (setLetter <= 8'h7A);
   assign up_char = is_lo ? (setLetter - 8'h20) : setLetter;
   assign cnt_dec = cnt_q - ONE;

   always_ff @(posedge clk or posedge nRst) begin
      if (nRst) begin
         state_q     <= IDLE;
         rsp_q       <= '0;
         cnt_q       <= '0;
         key_ready_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         rsp_q       <= rsp_n;
         cnt_q       <= cnt_n;
         key_ready_q <= key_ready;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      rsp_n   = '0;
      case (state_q)
         IDLE: begin
            // gameEnd wins priority here even though it has nothing to do
            if (!gameEnd_host && toggle_state) begin
               state_n        = ENTRY;
               cnt_n          = '0;
               rsp_n.clr_word = 1'b1;
            end
         end
         ENTRY: begin
            if (gameEnd_host) begin
               state_n        = IDLE;
               cnt_n          = '0;
               rsp_n.clr_word = 1'b1;
            end else if (key_ev) begin
               if (is_up || is_lo) begin
                  if (cnt_q < FULL) begin
                     rsp_n.wr_en   = 1'b1;
                     rsp_n.wr_idx  = cnt_q[IDX_W-1:0];
                     rsp_n.wr_data = up_char;
                     cnt_n         = cnt_q + ONE;
                  end else begin
                     rsp_n.key_err = 1'b1;
                  end
               end else if (setLetter == BKSP) begin
                  if (cnt_q != '0) begin
                     rsp_n.wr_en   = 1'b1;
                     rsp_n.wr_idx  = cnt_dec[IDX_W-1:0];
                     rsp_n.wr_data = BLANK;
                     cnt_n         = cnt_dec;
                  end else begin
                     rsp_n.key_err = 1'b1;
                  end
               end else if (setLetter == ENTER) begin
                  if (cnt_q == FULL) begin
                     state_n           = LOCKED;
                     rsp_n.word_commit = 1'b1;
                  end else begin
                     rsp_n.key_err = 1'b1;
                  end
               end else begin
                  rsp_n.key_err = 1'b1;
               end
            end
         end
         LOCKED: begin
            if (gameEnd_host) begin
               state_n        = IDLE;
               cnt_n          = '0;
               rsp_n.clr_word = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   assign wr_en       = rsp_q.wr_en;
   assign wr_idx      = rsp_q.wr_idx;
   assign wr_data     = rsp_q.wr_data;
   assign clr_word    = rsp_q.clr_word;
   assign word_commit = rsp_q.word_commit;
   assign key_err     = rsp_q.key_err;
   assign word_locked = (state_q == LOCKED);
   assign letter_cnt  = cnt_q;
   assign state       = state_q;

endmodule

// File: tb/tb_host_entry_ctrl.sv
// Scoreboard bench for host_entry_ctrl: a behavioural model pushes expected
// pulses as keys are driven; a negedge monitor pops them as the DUT responds.
module tb_host_entry_ctrl;

   localparam int IDX_W = 3;

   typedef struct packed {
      logic             wr_en;
      logic [IDX_W-1:0] idx;
      logic [7:0]       data;
      logic             clr;
      logic             commit;
      logic             err;
   } exp_t;

   logic             tb_clk = 1'b0;
   logic             nRst = 1'b1;
   logic             key_ready = 1'b0;
   logic [7:0]       setLetter = 8'h00;
   logic             toggle_state = 1'b0;
   logic             gameEnd_host = 1'b0;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [7:0]       wr_data;
   logic             clr_word;
   logic             word_commit;
   logic             word_locked;
   logic [IDX_W:0]   letter_cnt;
   logic             key_err;
   logic [1:0]       state;

   int   total = 0;
   int   bad = 0;
   exp_t sb_q[$];

   // bench-side model of the controller
   int   m_state = 0;
   int   m_cnt = 0;
   logic m_kq = 1'b0;

   host_entry_ctrl dut (
      .clk(tb_clk), .nRst(nRst), .key_ready(key_ready), .setLetter(setLetter),
      .toggle_state(toggle_state), .gameEnd_host(gameEnd_host),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .clr_word(clr_word),
      .word_commit(word_commit), .word_locked(word_locked),
      .letter_cnt(letter_cnt), .key_err(key_err), .state(state)
   );

   always #5 tb_clk = ~tb_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pop an expectation whenever the DUT emits any pulse.
   always @(negedge tb_clk) begin
      exp_t got, e;
      if (!nRst && (wr_en || clr_word || word_commit || key_err)) begin
         got.wr_en  = wr_en;
         got.idx    = wr_en ? wr_idx : '0;
         got.data   = wr_en ? wr_data : '0;
         got.clr    = clr_word;
         got.commit = word_commit;
         got.err    = key_err;
         if (sb_q.size() == 0) begin
            chk("unexpected_pulse", 32'(got), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("sb", 32'(got), 32'(e));
         end
      end
   end

   task automatic step(input logic kr, input logic [7:0] ch, input logic tog, input logic ge);
      exp_t e;
      logic ev, push, alpha;
      logic [7:0] up;
      @(negedge tb_clk);
      key_ready = kr; setLetter = ch; toggle_state = tog; gameEnd_host = ge;
      ev = kr && !m_kq;
      m_kq = kr;
      e = '0; push = 1'b0;
      alpha = (ch >= "A" && ch <= "Z") || (ch >= "a" && ch <= "z");
      up = (ch >= "a" && ch <= "z") ? ch - 8'd32 : ch;
      if (m_state == 0) begin
         if (!ge && tog) begin m_state = 1; m_cnt = 0; e.clr = 1'b1; push = 1'b1; end
      end else if (ge) begin
         m_state = 0; m_cnt = 0; e.clr = 1'b1; push = 1'b1;
      end else if (m_state == 1 && ev) begin
         push = 1'b1;
         if (alpha && m_cnt < 5) begin
            e.wr_en = 1'b1; e.idx = IDX_W'(m_cnt); e.data = up; m_cnt++;
         end else if (ch == 8'h08 && m_cnt > 0) begin
            m_cnt--; e.wr_en = 1'b1; e.idx = IDX_W'(m_cnt); e.data = 8'h5F;
         end else if (ch == 8'h0D && m_cnt == 5) begin
            m_state = 2; e.commit = 1'b1;
         end else begin
            e.err = 1'b1;
         end
      end
      if (push) sb_q.push_back(e);
   endtask

   task automatic press(input logic [7:0] ch);
      step(1'b1, ch, 1'b0, 1'b0);
      step(1'b0, ch, 1'b0, 1'b0);
   endtask

   task automatic settle(input string tag);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
      chk({tag, "_state"}, 32'(state), 32'(m_state));
      chk({tag, "_cnt"}, 32'(letter_cnt), 32'(m_cnt));
      chk({tag, "_locked"}, 32'(word_locked), 32'(m_state == 2));
   endtask

   initial begin
      repeat (3) @(negedge tb_clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_pulses", {wr_en, clr_word, word_commit, key_err, word_locked}, 32'd0);
      chk("rst_data", {wr_idx, wr_data, letter_cnt}, 32'd0);
      nRst = 1'b0;

      // toggle into entry, three letters with case folding
      step(1'b0, 8'h00, 1'b1, 1'b0);
      press("F"); press("a"); press("N");
      settle("entry3");
      chk("cnt_is_3", 32'(letter_cnt), 32'd3);

      // asynchronous reset mid-entry
      #2 nRst = 1'b1;
      #1;
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_cnt", 32'(letter_cnt), 32'd0);
      chk("mid_rst_pulses", {wr_en, clr_word, word_commit, key_err}, 32'd0);
      @(negedge tb_clk);
      nRst = 1'b0;
      m_state = 0; m_cnt = 0; m_kq = 1'b0;

      // keys in IDLE are ignored
      press("Q");
      settle("idle_keys");

      step(1'b0, 8'h00, 1'b1, 1'b0);
      press("F"); press("a"); press("N");
      press(8'h0D);                       // short word: error
      press(8'h08);                       // erase slot 2
      settle("bksp");
      chk("cnt_is_2", 32'(letter_cnt), 32'd2);

      press("x"); press("y"); press("Z");
      press("Q");                         // overflow
      press(8'h0D);                       // commit
      settle("commit");
      chk("locked", 32'(word_locked), 32'd1);
      press("B"); press(8'h08); press(8'h0D);
      step(1'b0, 8'h00, 1'b1, 1'b0);      // toggle ignored while locked
      settle("locked_keys");
      chk("locked_cnt", 32'(letter_cnt), 32'd5);

      // game end, re-enter, held key, invalid key, character boundaries
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      press(8'h08);                       // backspace at empty
      repeat (4) step(1'b1, "T", 1'b0, 1'b0);
      step(1'b0, "T", 1'b0, 1'b0);
      press("5"); press("@"); press("["); press(8'h60); press("{");
      press("z"); press("A");
      settle("held");
      chk("cnt_is_3b", 32'(letter_cnt), 32'd3);

      // game end and key in the same cycle; toggle and key in IDLE
      step(1'b1, "K", 1'b0, 1'b1);
      step(1'b0, "K", 1'b0, 1'b0);
      settle("ge_key");
      step(1'b1, "M", 1'b1, 1'b0);
      step(1'b0, "M", 1'b0, 1'b0);
      settle("tog_key");
      chk("tog_key_cnt0", 32'(letter_cnt), 32'd0);

      // key held across a state change must not fire on entry
      step(1'b1, "H", 1'b0, 1'b1);
      step(1'b1, "H", 1'b1, 1'b0);
      step(1'b1, "H", 1'b0, 1'b0);
      step(1'b0, "H", 1'b0, 1'b0);
      settle("held_xstate");
      chk("held_xstate_cnt", 32'(letter_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
